// File: rtl/macguffin_sbox_s123_pkg.sv
// Shared constants for the MacGuffin S1..S3 lookup: table type, widths and the three box contents.
// Entry index 0 of every table corresponds to selector value 0.
package macguffin_sbox_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 2;
    localparam int SBOX_DEPTH = 1 << SBOX_IN_W;

    // Ascending packed range, so the first concatenated entry lands at index 0.
    typedef logic [0:SBOX_DEPTH-1][SBOX_OUT_W-1:0] sbox_tbl_t;

    localparam sbox_tbl_t SBOX1 = {
        2'd2, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1,
        2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3,
        2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2,
        2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0,
        2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1,
        2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3
    };

    localparam sbox_tbl_t SBOX2 = {
        2'd3, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1,
        2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2,
        2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd1,
        2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1,
        2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0,
        2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2,
        2'd3, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3
    };

    localparam sbox_tbl_t SBOX3 = {
        2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3,
        2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2,
        2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2,
        2'd3, 2'd2, 2'd0, 2'd3, 2'd0, 2'd3, 2'd2, 2'd1,
        2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0,
        2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1,
        2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1,
        2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2
    };

endpackage

// File: rtl/macguffin_sbox_s123_if.sv
// Selector in / three S-box results out, as seen by the lookup block and its driver.
interface macguffin_sbox_s123_if;
    import macguffin_sbox_pkg::*;

    // in_valid qualifies iword for the edge it is sampled on; there is no ready, the
    // block accepts every cycle. out_valid marks oword_s1/s2/s3 as a fresh result
    // for exactly one cycle per accepted word.
    logic                  in_valid;
    logic [SBOX_IN_W-1:0]  iword;
    logic                  out_valid;
    logic [SBOX_OUT_W-1:0] oword_s1;
    logic [SBOX_OUT_W-1:0] oword_s2;
    logic [SBOX_OUT_W-1:0] oword_s3;

    modport master (
        output in_valid,
        output iword,
        input  out_valid,
        input  oword_s1,
        input  oword_s2,
        input  oword_s3
    );

    modport slave (
        input  in_valid,
        input  iword,
        output out_valid,
        output oword_s1,
        output oword_s2,
        output oword_s3
    );

endinterface

// File: rtl/macguffin_sbox_s123_lut.sv
// Combinational 6-to-2 S-box lookup; the box contents come in through TABLE.
module mg_sbox_lut
    import macguffin_sbox_pkg::*;
#(
    parameter sbox_tbl_t TABLE = SBOX1
) (
    input  logic [SBOX_IN_W-1:0]  i_idx,
    output logic [SBOX_OUT_W-1:0] o_val
);

    assign o_val = TABLE[i_idx];

endmodule

// File: rtl/macguffin_sbox_s123.sv
// Registered S1/S2/S3 lookup: one shared selector, three 2-bit results, one-cycle latency.
module macguffin_sbox_s123
    import macguffin_sbox_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    macguffin_sbox_s123_if.slave  sb
);

    logic [SBOX_OUT_W-1:0] w_s1;
    logic [SBOX_OUT_W-1:0] w_s2;
    logic [SBOX_OUT_W-1:0] w_s3;

    logic                  r_valid;
    logic [SBOX_OUT_W-1:0] r_s1;
    logic [SBOX_OUT_W-1:0] r_s2;
    logic [SBOX_OUT_W-1:0] r_s3;

    mg_sbox_lut #(.TABLE(SBOX1)) u_s1 (.i_idx(sb.iword), .o_val(w_s1));
    mg_sbox_lut #(.TABLE(SBOX2)) u_s2 (.i_idx(sb.iword), .o_val(w_s2));
    mg_sbox_lut #(.TABLE(SBOX3)) u_s3 (.i_idx(sb.iword), .o_val(w_s3));

    // Data registers only load on an accepted word, so idle cycles keep the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
        end else begin
            r_valid <= sb.in_valid;
            if (sb.in_valid) begin
                r_s1 <= w_s1;
                r_s2 <= w_s2;
                r_s3 <= w_s3;
            end
        end
    end

    assign sb.out_valid = r_valid;
    assign sb.oword_s1  = r_s1;
    assign sb.oword_s2  = r_s2;
    assign sb.oword_s3  = r_s3;

endmodule

// File: tb/tb_macguffin_sbox_s123.sv
// Directed bench for macguffin_sbox_s123: reference tables kept as digit strings, scoreboard queue.
module tb_macguffin_sbox_s123;

    localparam int W = 7;

    logic clk;
    logic rst;

    macguffin_sbox_s123_if bus ();

    macguffin_sbox_s123 dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    string s1_tbl = {"20033110", "02303321", "12200223", "13310112",
                     "03122220", "30030131", "31233112", "12201003"};
    string s2_tbl = {"31132021", "03301202", "32100132", "20031321",
                     "03221231", "21033010", "13202102", "30110233"};
    string s3_tbl = {"23013023", "01103012", "10322112", "32030321",
                     "31020330", "20331201", "30130221", "13212012"};

    logic [W-1:0] exp_q[$];
    int n_asserts = 0;
    int n_fail    = 0;

    // reference model state
    logic       m_valid = 1'b0;
    logic [1:0] m_s1 = 2'd0;
    logic [1:0] m_s2 = 2'd0;
    logic [1:0] m_s3 = 2'd0;

    function automatic logic [1:0] tbl(input string s, input int idx);
        int d;
        d = int'(s.getc(idx)) - 48;
        return d[1:0];
    endfunction

    task automatic check(input string tag);
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        if (exp_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard, expected one entry", tag);
        end else begin
            exp = exp_q.pop_front();
            obs = {bus.out_valid, bus.oword_s1, bus.oword_s2, bus.oword_s3};
            n_asserts++;
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed v=%b s=%0d/%0d/%0d expected v=%b s=%0d/%0d/%0d",
                       tag, obs[6], obs[5:4], obs[3:2], obs[1:0],
                       exp[6], exp[5:4], exp[3:2], exp[1:0]);
            end
        end
    endtask

    // driver: one clock per call, model updated and result queued when driven
    task automatic step(input logic r, input logic v, input logic [5:0] w, input string tag);
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.iword    = w;
        if (r) begin
            m_valid = 1'b0;
            m_s1 = 2'd0; m_s2 = 2'd0; m_s3 = 2'd0;
        end else begin
            m_valid = v;
            if (v) begin
                m_s1 = tbl(s1_tbl, int'(w));
                m_s2 = tbl(s2_tbl, int'(w));
                m_s3 = tbl(s3_tbl, int'(w));
            end
        end
        exp_q.push_back({m_valid, m_s1, m_s2, m_s3});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.iword    = '0;

        // reset for two cycles, then first lookup of index 0
        step(1'b1, 1'b0, 6'd0, "reset0");
        step(1'b1, 1'b1, 6'd0, "reset1");
        step(1'b0, 1'b1, 6'd0, "first_idx0");

        // corner indices
        step(1'b0, 1'b1, 6'd63, "idx63");
        step(1'b0, 1'b1, 6'd8,  "idx8");
        step(1'b0, 1'b1, 6'd5,  "idx5");
        step(1'b0, 1'b1, 6'd44, "idx44");

        // exhaustive back-to-back sweep
        for (int i = 0; i < 64; i++)
            step(1'b0, 1'b1, 6'(i), "sweep");

        // hold: one valid word, then idle with a toggling selector
        step(1'b0, 1'b1, 6'd44, "hold_load");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 6'($urandom_range(0, 63)), "hold_idle");

        // reset in the middle of a valid stream
        for (int i = 0; i < 20; i++)
            step((i == 10 || i == 11) ? 1'b1 : 1'b0, 1'b1, 6'(i + 30), "midrst");

        // alternating valid gaps on 16..23
        for (int i = 16; i < 24; i++)
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 6'(i), "gaps");
        step(1'b0, 1'b1, 6'd18, "idx18");

        // random tail
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
